// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises Rx, qualifies the start bit, samples each
// bit mid-period and drives rx_bit/shift/load_buffer into the RX buffer register.
module uart_rx_ctrl #(
  parameter int BAUD_DIV   = 27,
  parameter int OVERSAMPLE = 16
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic Rx,
  input  logic clr_ferr,
  output logic rx_bit,
  output logic shift,
  output logic load_buffer,
  output logic busy,
  output logic framing_err
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [2:0]    bcnt;
  logic          shift_req;
  logic          load_req;
  logic          tick;

  // Two-flop synchroniser; idles high so a reset never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (tcnt == T_LAST);

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      scnt        <= '0;
      bcnt        <= '0;
      shift_req   <= 1'b0;
      load_req    <= 1'b0;
      rx_bit      <= 1'b1;
      shift       <= 1'b0;
      load_buffer <= 1'b0;
      busy        <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      // Pulses are delayed one cycle so rx_bit is already stable when shift rises.
      shift       <= shift_req;
      load_buffer <= load_req;
      shift_req   <= 1'b0;
      load_req    <= 1'b0;

      if (state == ST_IDLE || tick) tcnt <= '0;
      else                          tcnt <= tcnt + T_ONE;

      if (tick) scnt <= scnt + S_ONE;

      // A new error assigned later in this block overrides the clear.
      if (clr_ferr) framing_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            busy  <= 1'b1;
            scnt  <= '0;
          end
        end
        ST_START: begin
          if (tick && scnt == S_HALF) begin
            scnt <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
              bcnt  <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (tick && scnt == S_LAST) begin
            scnt      <= '0;
            rx_bit    <= rx_s;
            shift_req <= 1'b1;
            bcnt      <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick && scnt == S_LAST) begin
            scnt <= '0;
            if (rx_s) begin
              load_req <= 1'b1;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state       <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Only a return to idle-high re-arms start detection.
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            scnt  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: drives serial frames bit-by-bit and checks
// the shift/load_buffer event log against the expected frame contents and timing.
module tb_uart_rx_ctrl;

  localparam int BD  = 4;
  localparam int OS  = 16;
  localparam int BIT = BD * OS;

  logic CLOCK = 1'b0;
  logic reset = 1'b1;
  logic Rx = 1'b1;
  logic clr_ferr = 1'b0;
  logic rx_bit, shift, load_buffer, busy, framing_err;

  int tests = 0;
  int fails = 0;

  int   cyc = 0;
  int   shift_cyc[$];
  logic shift_val[$];
  int   load_cyc[$];
  int   overlap = 0;

  logic [7:0] bg_data;
  logic       bg_stop;
  logic       bg_done;
  int         bg_t0;

  uart_rx_ctrl #(.BAUD_DIV(BD), .OVERSAMPLE(OS)) dut (
    .CLOCK(CLOCK), .reset(reset), .Rx(Rx), .clr_ferr(clr_ferr),
    .rx_bit(rx_bit), .shift(shift), .load_buffer(load_buffer),
    .busy(busy), .framing_err(framing_err)
  );

  always #5 CLOCK = ~CLOCK;

  // Event log sampled on the falling edge, away from the active edge.
  always @(negedge CLOCK) begin
    cyc++;
    if (shift) begin
      shift_cyc.push_back(cyc);
      shift_val.push_back(rx_bit);
    end
    if (load_buffer) load_cyc.push_back(cyc);
    if (shift && load_buffer) overlap++;
  end

  task automatic clear_log();
    shift_cyc.delete();
    shift_val.delete();
    load_cyc.delete();
  endtask

  // Start bit, 8 data bits LSB first, one stop bit; each held one bit period.
  task automatic drive_frame(input logic [7:0] data, input logic stop_val, output int t0);
    t0 = cyc;
    Rx = 1'b0;
    repeat (BIT) @(negedge CLOCK);
    for (int i = 0; i < 8; i++) begin
      Rx = data[i];
      repeat (BIT) @(negedge CLOCK);
    end
    Rx = stop_val;
    repeat (BIT) @(negedge CLOCK);
  endtask

  task automatic bg_send();
    bg_done = 1'b0;
    fork
      begin
        drive_frame(bg_data, bg_stop, bg_t0);
        bg_done = 1'b1;
      end
    join_none
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLOCK);
    tests++; if (rx_bit !== 1'b1)      begin fails++; $display("FAIL reset_rx_bit got=%b exp=1", rx_bit); end
    tests++; if (shift !== 1'b0)       begin fails++; $display("FAIL reset_shift got=%b exp=0", shift); end
    tests++; if (load_buffer !== 1'b0) begin fails++; $display("FAIL reset_load got=%b exp=0", load_buffer); end
    tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (framing_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got=%b exp=0", framing_err); end
    reset = 1'b0;
    repeat (5) @(negedge CLOCK);
  endtask

  // 0x55 first, then random bytes with random idle gaps; all with a good stop bit.
  task automatic test_frames();
    logic [7:0] data;
    int t0, lat;
    for (int f = 0; f < 6; f++) begin
      data = (f == 0) ? 8'h55 : 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 50)) @(negedge CLOCK);
      clear_log();
      drive_frame(data, 1'b1, t0);
      repeat (8) @(negedge CLOCK);
      tests++;
      if (shift_cyc.size() !== 8) begin
        fails++; $display("FAIL frame%0d shift_count got=%0d exp=8", f, shift_cyc.size());
      end else begin
        for (int k = 0; k < 8; k++) begin
          tests++;
          if (shift_val[k] !== data[k]) begin
            fails++; $display("FAIL frame%0d bit%0d got=%b exp=%b", f, k, shift_val[k], data[k]);
          end
          if (k > 0) begin
            tests++;
            if (shift_cyc[k] - shift_cyc[k-1] !== BIT) begin
              fails++; $display("FAIL frame%0d spacing%0d got=%0d exp=%0d", f, k, shift_cyc[k] - shift_cyc[k-1], BIT);
            end
          end
        end
        // First sample lands mid data bit 0: 1.5 bit periods plus a few cycles of sync/pipeline.
        lat = shift_cyc[0] - t0;
        tests++;
        if (lat < BIT + BIT / 2 - 4 || lat > BIT + BIT / 2 + 12) begin
          fails++; $display("FAIL frame%0d first_shift_latency got=%0d exp~%0d", f, lat, BIT + BIT / 2);
        end
        tests++;
        if (load_cyc.size() === 1 && load_cyc[0] - shift_cyc[7] !== BIT) begin
          fails++; $display("FAIL frame%0d load_spacing got=%0d exp=%0d", f, load_cyc[0] - shift_cyc[7], BIT);
        end
      end
      tests++; if (load_cyc.size() !== 1) begin fails++; $display("FAIL frame%0d load_count got=%0d exp=1", f, load_cyc.size()); end
      tests++; if (framing_err !== 1'b0)  begin fails++; $display("FAIL frame%0d ferr got=%b exp=0", f, framing_err); end
      tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL frame%0d busy_after got=%b exp=0", f, busy); end
    end
  endtask

  task automatic test_glitch();
    int len;
    for (int g = 0; g < 3; g++) begin
      len = (g == 0) ? 10 : $urandom_range(2, 25);
      clear_log();
      Rx = 1'b0;
      repeat (len) @(negedge CLOCK);
      Rx = 1'b1;
      repeat (8 - ((len < 8) ? len : 8)) @(negedge CLOCK);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch%0d busy_during got=%b exp=1", g, busy); end
      repeat (40 - ((len > 8) ? len : 8)) @(negedge CLOCK);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch%0d busy_40 got=%b exp=0", g, busy); end
      repeat (BIT * 12) @(negedge CLOCK);
      tests++; if (shift_cyc.size() !== 0) begin fails++; $display("FAIL glitch%0d shifts got=%0d exp=0", g, shift_cyc.size()); end
      tests++; if (load_cyc.size() !== 0)  begin fails++; $display("FAIL glitch%0d loads got=%0d exp=0", g, load_cyc.size()); end
      tests++; if (framing_err !== 1'b0)   begin fails++; $display("FAIL glitch%0d ferr got=%b exp=0", g, framing_err); end
    end
  endtask

  task automatic test_framing_error();
    logic [7:0] data;
    int t0;
    data = 8'hA3;
    clear_log();
    drive_frame(data, 1'b0, t0);
    Rx = 1'b1;
    repeat (8) @(negedge CLOCK);
    tests++;
    if (shift_cyc.size() !== 8) begin
      fails++; $display("FAIL ferr_frame shift_count got=%0d exp=8", shift_cyc.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (shift_val[k] !== data[k]) begin
          fails++; $display("FAIL ferr_frame bit%0d got=%b exp=%b", k, shift_val[k], data[k]);
        end
      end
    end
    tests++; if (load_cyc.size() !== 0) begin fails++; $display("FAIL ferr_frame loads got=%0d exp=0", load_cyc.size()); end
    tests++; if (framing_err !== 1'b1)  begin fails++; $display("FAIL ferr_frame ferr got=%b exp=1", framing_err); end
    tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL ferr_frame busy got=%b exp=0", busy); end
    repeat (5) @(negedge CLOCK);
    tests++; if (framing_err !== 1'b1)  begin fails++; $display("FAIL ferr_sticky got=%b exp=1", framing_err); end
    clr_ferr = 1'b1;
    @(negedge CLOCK);
    clr_ferr = 1'b0;
    tests++; if (framing_err !== 1'b0)  begin fails++; $display("FAIL ferr_clear got=%b exp=0", framing_err); end
  endtask

  task automatic test_break();
    int t0;
    clear_log();
    Rx = 1'b0;
    repeat (2000) @(negedge CLOCK);
    Rx = 1'b1;
    repeat (10) @(negedge CLOCK);
    tests++; if (shift_cyc.size() !== 8) begin fails++; $display("FAIL break shifts got=%0d exp=8", shift_cyc.size()); end
    for (int k = 0; k < shift_cyc.size(); k++) begin
      tests++;
      if (shift_val[k] !== 1'b0) begin fails++; $display("FAIL break bit%0d got=%b exp=0", k, shift_val[k]); end
    end
    tests++; if (load_cyc.size() !== 0) begin fails++; $display("FAIL break loads got=%0d exp=0", load_cyc.size()); end
    tests++; if (framing_err !== 1'b1)  begin fails++; $display("FAIL break ferr got=%b exp=1", framing_err); end
    tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL break busy got=%b exp=0", busy); end
    clr_ferr = 1'b1;
    @(negedge CLOCK);
    clr_ferr = 1'b0;
    clear_log();
    drive_frame(8'h0F, 1'b1, t0);
    repeat (8) @(negedge CLOCK);
    tests++; if (shift_cyc.size() !== 8) begin fails++; $display("FAIL after_break shifts got=%0d exp=8", shift_cyc.size()); end
    for (int k = 0; k < shift_cyc.size(); k++) begin
      tests++;
      if (shift_val[k] !== ((8'h0F >> k) & 8'h01) ? 1'b1 : 1'b0) begin
        fails++; $display("FAIL after_break bit%0d got=%b", k, shift_val[k]);
      end
    end
    tests++; if (load_cyc.size() !== 1) begin fails++; $display("FAIL after_break loads got=%0d exp=1", load_cyc.size()); end
    tests++; if (framing_err !== 1'b0)  begin fails++; $display("FAIL after_break ferr got=%b exp=0", framing_err); end
  endtask

  task automatic test_reset_mid_frame();
    int budget;
    // Bits 3..7 are high so the frame remainder cannot look like a new start bit.
    bg_data = 8'hF8 | 8'($urandom_range(0, 7));
    bg_stop = 1'b1;
    clear_log();
    bg_send();
    budget = 0;
    while (shift_cyc.size() < 4 && budget < 2000) begin
      @(negedge CLOCK);
      budget++;
    end
    tests++; if (shift_cyc.size() < 4) begin fails++; $display("FAIL midreset wait_4th_shift got=%0d exp=4", shift_cyc.size()); end
    reset = 1'b1;
    @(negedge CLOCK);
    tests++; if (rx_bit !== 1'b1)      begin fails++; $display("FAIL midreset_rx_bit got=%b exp=1", rx_bit); end
    tests++; if (shift !== 1'b0)       begin fails++; $display("FAIL midreset_shift got=%b exp=0", shift); end
    tests++; if (load_buffer !== 1'b0) begin fails++; $display("FAIL midreset_load got=%b exp=0", load_buffer); end
    tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    tests++; if (framing_err !== 1'b0) begin fails++; $display("FAIL midreset_ferr got=%b exp=0", framing_err); end
    reset = 1'b0;
    budget = 0;
    while (!bg_done && budget < 2000) begin
      @(negedge CLOCK);
      budget++;
    end
    tests++; if (bg_done !== 1'b1) begin fails++; $display("FAIL midreset frame_end got=%b exp=1", bg_done); end
    repeat (BIT) @(negedge CLOCK);
    tests++; if (shift_cyc.size() !== 4) begin fails++; $display("FAIL midreset shifts got=%0d exp=4", shift_cyc.size()); end
    tests++; if (load_cyc.size() !== 0)  begin fails++; $display("FAIL midreset loads got=%0d exp=0", load_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [2];
    int t0, budget;
    logic seen;
    bytes[0] = 8'hFF;
    bytes[1] = 8'h00;
    clear_log();
    drive_frame(bytes[0], 1'b1, t0);
    drive_frame(bytes[1], 1'b1, t0);
    repeat (8) @(negedge CLOCK);
    tests++; if (shift_cyc.size() !== 16) begin fails++; $display("FAIL b2b shifts got=%0d exp=16", shift_cyc.size()); end
    tests++; if (load_cyc.size() !== 2)   begin fails++; $display("FAIL b2b loads got=%0d exp=2", load_cyc.size()); end
    if (shift_cyc.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        tests++;
        if (shift_val[k] !== bytes[k / 8][k % 8]) begin
          fails++; $display("FAIL b2b bit%0d got=%b exp=%b", k, shift_val[k], bytes[k / 8][k % 8]);
        end
      end
    end
    if (load_cyc.size() == 2) begin
      tests++;
      if (load_cyc[1] - load_cyc[0] !== 10 * BIT) begin
        fails++; $display("FAIL b2b load_period got=%0d exp=%0d", load_cyc[1] - load_cyc[0], 10 * BIT);
      end
    end

    // clr_ferr held high across the cycle in which a stop error is detected.
    tests++; if (framing_err !== 1'b0) begin fails++; $display("FAIL race_pre ferr got=%b exp=0", framing_err); end
    bg_data = 8'($urandom_range(0, 255));
    bg_stop = 1'b0;
    clear_log();
    bg_send();
    budget = 0;
    while (shift_cyc.size() < 8 && budget < 2000) begin
      @(negedge CLOCK);
      budget++;
    end
    clr_ferr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 * BIT && !seen; i++) begin
      @(negedge CLOCK);
      if (framing_err) seen = 1'b1;
    end
    clr_ferr = 1'b0;
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL race_set_wins got=%b exp=1", seen); end
    repeat (3) @(negedge CLOCK);
    tests++; if (framing_err !== 1'b1) begin fails++; $display("FAIL race_hold ferr got=%b exp=1", framing_err); end
    budget = 0;
    while (!bg_done && budget < 2000) begin
      @(negedge CLOCK);
      budget++;
    end
    Rx = 1'b1;
    repeat (5) @(negedge CLOCK);
    tests++; if (load_cyc.size() !== 0) begin fails++; $display("FAIL race loads got=%0d exp=0", load_cyc.size()); end
    clr_ferr = 1'b1;
    @(negedge CLOCK);
    clr_ferr = 1'b0;
  endtask

  initial begin
    bg_done = 1'b1;
    bg_data = 8'h00;
    bg_stop = 1'b1;
    bg_t0   = 0;
    @(negedge CLOCK);
    test_reset();
    test_frames();
    test_glitch();
    test_framing_error();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();
    tests++; if (overlap !== 0) begin fails++; $display("FAIL shift_load_overlap got=%0d exp=0", overlap); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
